// File: rtl/acl_txbuf_ctrl_if.sv
// ACL TX buffer bus: MCU commit side, arqflowctrl decisions and encoder side.
// master drives the requests; slave is the buffer controller.
`timescale 1ns/1ps
interface acl_txbuf_ctrl_if #(
  parameter int LEN_W = 10
) ();
  logic             conns_new;
  logic             mcu_commit_p;
  logic [LEN_W-1:0] mcu_len;
  logic [1:0]       mcu_llid;
  logic             tx_slot_p;
  logic             sendnewpy;
  logic             sendoldpy;
  logic             send0py;
  logic             remote_go;
  logic             tx_rd_p;
  logic             wr_sel;
  logic             buf_full;
  logic             commit_err_p;
  logic             tx_valid;
  logic             tx_sel;
  logic [LEN_W-1:0] tx_len;
  logic [1:0]       tx_llid;
  logic [LEN_W-1:0] tx_rdaddr;
  logic             tx_rd_last;
  logic             tx_done_p;

  modport master (
    output conns_new, mcu_commit_p, mcu_len, mcu_llid,
    output tx_slot_p, sendnewpy, sendoldpy, send0py,
    output remote_go, tx_rd_p,
    input  wr_sel, buf_full, commit_err_p,
    input  tx_valid, tx_sel, tx_len, tx_llid,
    input  tx_rdaddr, tx_rd_last, tx_done_p
  );

  modport slave (
    input  conns_new, mcu_commit_p, mcu_len, mcu_llid,
    input  tx_slot_p, sendnewpy, sendoldpy, send0py,
    input  remote_go, tx_rd_p,
    output wr_sel, buf_full, commit_err_p,
    output tx_valid, tx_sel, tx_len, tx_llid,
    output tx_rdaddr, tx_rd_last, tx_done_p
  );
endinterface

// File: rtl/acl_txbuf_ctrl.sv
// Ping-pong ACL TX payload buffer manager between MCU and packet encoder.
// Slots are filled at wp, transmitted from rp; acked slots return to MCU.
`timescale 1ns/1ps
module acl_txbuf_ctrl #(
  parameter int LEN_W   = 10,
  parameter int MAX_LEN = 339
) (
  input logic          clk_6M,
  input logic          rstz,
  acl_txbuf_ctrl_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_INFL
  } st_t;

  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  st_t              st_q, st_d;
  logic [1:0]       vld_q, vld_d;
  logic [LEN_W-1:0] len_q [2];
  logic [LEN_W-1:0] len_d [2];
  logic [1:0]       llid_q [2];
  logic [1:0]       llid_d [2];
  logic             wp_q, wp_d;
  logic             rp_q, rp_d;
  logic             txv_q, txv_d;
  logic             txsel_q, txsel_d;
  logic [LEN_W-1:0] txlen_q, txlen_d;
  logic [1:0]       txllid_q, txllid_d;
  logic [LEN_W-1:0] rdaddr_q, rdaddr_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             commit_ok;
  logic             do_zero;
  logic             do_old;
  logic             do_new;
  logic             try_sel;
  logic             sel_idx;
  logic             rd_ok;

  // Decision terms; flush beats retransmit beats new payload.
  assign commit_ok = !vld_q[wp_q] && (bus.mcu_len <= MAX_L);
  assign do_zero   = bus.send0py;
  assign do_old    = bus.sendoldpy & ~bus.send0py;
  assign do_new    = bus.sendnewpy & ~bus.sendoldpy & ~bus.send0py;
  assign rd_ok     = txv_q && (txlen_q != '0)
                  && (rdaddr_q != txlen_q - 1'b1);

  // State register for FSM, slot table and registered outputs.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      st_q     <= S_IDLE;
      vld_q    <= '0;
      len_q    <= '{default: '0};
      llid_q   <= '{default: '0};
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      txv_q    <= 1'b0;
      txsel_q  <= 1'b0;
      txlen_q  <= '0;
      txllid_q <= '0;
      rdaddr_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      vld_q    <= vld_d;
      len_q    <= len_d;
      llid_q   <= llid_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      txv_q    <= txv_d;
      txsel_q  <= txsel_d;
      txlen_q  <= txlen_d;
      txllid_q <= txllid_d;
      rdaddr_q <= rdaddr_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next state: commit, byte reads, TX slot decision, then conns_new wipe.
  always_comb begin
    st_d     = st_q;
    vld_d    = vld_q;
    len_d    = len_q;
    llid_d   = llid_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    txv_d    = txv_q;
    txsel_d  = txsel_q;
    txlen_d  = txlen_q;
    txllid_d = txllid_q;
    rdaddr_d = rdaddr_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    try_sel  = 1'b0;
    sel_idx  = rp_q;

    // Commit sees pre-cycle valid bits, so a free this cycle cannot help.
    if (bus.mcu_commit_p) begin
      if (commit_ok) begin
        vld_d[wp_q]  = 1'b1;
        len_d[wp_q]  = bus.mcu_len;
        llid_d[wp_q] = bus.mcu_llid;
        wp_d         = ~wp_q;
      end else begin
        err_d = 1'b1;
      end
    end

    if (bus.tx_rd_p && rd_ok) begin
      rdaddr_d = rdaddr_q + 1'b1;
    end

    if (bus.tx_slot_p) begin
      txv_d = 1'b0;
      unique case (st_q)
        S_INFL: begin
          unique case (1'b1)
            do_zero: begin
              vld_d[rp_q] = 1'b0;
              rp_d        = ~rp_q;
              done_d      = 1'b1;
              txv_d       = 1'b1;
              txlen_d     = '0;
              txllid_d    = 2'b01;
              rdaddr_d    = '0;
              st_d        = S_IDLE;
            end
            do_old: begin
              txv_d    = 1'b1;
              rdaddr_d = '0;
            end
            do_new: begin
              vld_d[rp_q] = 1'b0;
              rp_d        = ~rp_q;
              done_d      = 1'b1;
              st_d        = S_IDLE;
              try_sel     = 1'b1;
              sel_idx     = ~rp_q;
            end
            default: ;
          endcase
        end
        default: try_sel = 1'b1;
      endcase

      if (try_sel && vld_q[sel_idx] && bus.remote_go) begin
        txv_d    = 1'b1;
        txsel_d  = sel_idx;
        txlen_d  = len_q[sel_idx];
        txllid_d = llid_q[sel_idx];
        rdaddr_d = '0;
        rp_d     = sel_idx;
        st_d     = S_INFL;
      end
    end

    if (bus.conns_new) begin
      st_d     = S_IDLE;
      vld_d    = '0;
      len_d    = '{default: '0};
      llid_d   = '{default: '0};
      wp_d     = 1'b0;
      rp_d     = 1'b0;
      txv_d    = 1'b0;
      txsel_d  = 1'b0;
      txlen_d  = '0;
      txllid_d = '0;
      rdaddr_d = '0;
      done_d   = 1'b0;
      err_d    = 1'b0;
    end
  end

  assign bus.wr_sel       = wp_q;
  assign bus.buf_full     = vld_q[0] & vld_q[1];
  assign bus.commit_err_p = err_q;
  assign bus.tx_valid     = txv_q;
  assign bus.tx_sel       = txsel_q;
  assign bus.tx_len       = txlen_q;
  assign bus.tx_llid      = txllid_q;
  assign bus.tx_rdaddr    = rdaddr_q;
  assign bus.tx_rd_last   = (txlen_q != '0)
                         && (rdaddr_q == txlen_q - 1'b1);
  assign bus.tx_done_p    = done_q;

endmodule
